// File: rtl/usb_link_arb_if.sv
// Shared application-buffer bus: one side issues write/commit/arm strobes,
// the other side returns ready, acks and read-back data.
interface usb_link_arb_if;
  logic        buf_in_wren;
  logic        buf_in_commit;
  logic        buf_out_arm;
  logic        buf_in_ready;
  logic        buf_in_commit_ack;
  logic        buf_out_arm_ack;
  logic        buf_out_hasdata;
  logic [7:0]  buf_out_q;
  logic [10:0] buf_out_len;

  // master issues requests (app toward arbiter, arbiter toward a core)
  modport master (
    output buf_in_wren, buf_in_commit, buf_out_arm,
    input  buf_in_ready, buf_in_commit_ack, buf_out_arm_ack,
           buf_out_hasdata, buf_out_q, buf_out_len
  );

  modport slave (
    input  buf_in_wren, buf_in_commit, buf_out_arm,
    output buf_in_ready, buf_in_commit_ack, buf_out_arm_ack,
           buf_out_hasdata, buf_out_q, buf_out_len
  );
endinterface

// File: rtl/usb_link_arb.sv
// Grants the shared application buffer bus to exactly one of the usb3/usb2 cores,
// based on link status, draining in-flight commit/arm handshakes before handing over.
module usb_link_arb #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter bit PREFER_USB3   = 1'b1
) (
  input  logic ext_clk,
  input  logic reset,
  input  logic u3_link_up,
  input  logic u2_connected,
  usb_link_arb_if.slave  app,
  usb_link_arb_if.master u3,
  usb_link_arb_if.master u2,
  output logic sel_usb3,
  output logic sel_usb2,
  output logic arb_busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST    = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_NONE,
    ST_SETTLE,
    ST_OWN3,
    ST_OWN2,
    ST_DRAIN
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cand_u3, cand_u3_d;
  logic             sel_usb3_d, sel_usb2_d;
  logic             commit_pend, commit_pend_d;
  logic             arm_pend, arm_pend_d;

  logic own3, own2;
  assign own3 = (state == ST_OWN3);
  assign own2 = (state == ST_OWN2);

  // Requests reach a core only while it actively owns the bus, never in DRAIN.
  assign u3.buf_in_wren   = own3 & app.buf_in_wren;
  assign u3.buf_in_commit = own3 & app.buf_in_commit;
  assign u3.buf_out_arm   = own3 & app.buf_out_arm;
  assign u2.buf_in_wren   = own2 & app.buf_in_wren;
  assign u2.buf_in_commit = own2 & app.buf_in_commit;
  assign u2.buf_out_arm   = own2 & app.buf_out_arm;

  // Return path follows the registered sel_* so acks still reach the app while draining.
  assign app.buf_in_ready      = (own3 & u3.buf_in_ready) | (own2 & u2.buf_in_ready);
  assign app.buf_in_commit_ack = (sel_usb3 & u3.buf_in_commit_ack) | (sel_usb2 & u2.buf_in_commit_ack);
  assign app.buf_out_arm_ack   = (sel_usb3 & u3.buf_out_arm_ack) | (sel_usb2 & u2.buf_out_arm_ack);
  assign app.buf_out_hasdata   = (sel_usb3 & u3.buf_out_hasdata) | (sel_usb2 & u2.buf_out_hasdata);
  assign app.buf_out_q         = ({8{sel_usb3}} & u3.buf_out_q) | ({8{sel_usb2}} & u2.buf_out_q);
  assign app.buf_out_len       = ({11{sel_usb3}} & u3.buf_out_len) | ({11{sel_usb2}} & u2.buf_out_len);

  assign arb_busy = (state == ST_SETTLE) || (state == ST_DRAIN);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state;
    cnt_d      = cnt;
    cand_u3_d  = cand_u3;
    sel_usb3_d = sel_usb3;
    sel_usb2_d = sel_usb2;
    // A request forwarded in the same cycle as its ack keeps the flag set.
    commit_pend_d = (u3.buf_in_commit | u2.buf_in_commit) | (commit_pend & ~app.buf_in_commit_ack);
    arm_pend_d    = (u3.buf_out_arm | u2.buf_out_arm) | (arm_pend & ~app.buf_out_arm_ack);

    unique case (state)
      ST_NONE: begin
        if (u3_link_up) begin
          state_d   = ST_SETTLE;
          cand_u3_d = 1'b1;
          cnt_d     = SETTLE_RELOAD;
        end else if (u2_connected) begin
          state_d   = ST_SETTLE;
          cand_u3_d = 1'b0;
          cnt_d     = SETTLE_RELOAD;
        end
      end
      ST_SETTLE: begin
        if (cand_u3 ? !u3_link_up : !u2_connected) begin
          state_d = ST_NONE;
          cnt_d   = '0;
        end else if (!cand_u3 && u3_link_up) begin
          cand_u3_d = 1'b1;
          cnt_d     = SETTLE_RELOAD;
        end else if (cnt == '0) begin
          state_d    = cand_u3 ? ST_OWN3 : ST_OWN2;
          sel_usb3_d = cand_u3;
          sel_usb2_d = !cand_u3;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_OWN3: begin
        if (!u3_link_up) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_OWN2: begin
        if (!u2_connected || (PREFER_USB3 && u3_link_up)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if ((!commit_pend && !arm_pend) || (cnt == DRAIN_LAST)) begin
          state_d       = ST_NONE;
          cnt_d         = '0;
          sel_usb3_d    = 1'b0;
          sel_usb2_d    = 1'b0;
          commit_pend_d = 1'b0;
          arm_pend_d    = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  always_ff @(posedge ext_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (reset) begin
      state       <= ST_NONE;
      cnt         <= '0;
      cand_u3     <= 1'b0;
      sel_usb3    <= 1'b0;
      sel_usb2    <= 1'b0;
      commit_pend <= 1'b0;
      arm_pend    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cand_u3     <= cand_u3_d;
      sel_usb3    <= sel_usb3_d;
      sel_usb2    <= sel_usb2_d;
      commit_pend <= commit_pend_d;
      arm_pend    <= arm_pend_d;
    end
  end

endmodule

// File: tb/tb_usb_link_arb.sv
// Self-checking bench for usb_link_arb: directed ownership scenarios followed by
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_usb_link_arb;

  localparam int S  = 16;
  localparam int DT = 24;
  localparam bit PREFER = 1'b1;

  logic ext_clk;
  logic reset;
  logic u3_link_up, u2_connected;
  logic sel_usb3, sel_usb2, arb_busy;

  usb_link_arb_if app_if ();
  usb_link_arb_if u3_if ();
  usb_link_arb_if u2_if ();

  usb_link_arb #(.SETTLE_CYCLES(S), .DRAIN_TIMEOUT(DT), .PREFER_USB3(PREFER)) dut (
    .ext_clk      (ext_clk),
    .reset        (reset),
    .u3_link_up   (u3_link_up),
    .u2_connected (u2_connected),
    .app          (app_if),
    .u3           (u3_if),
    .u2           (u2_if),
    .sel_usb3     (sel_usb3),
    .sel_usb2     (sel_usb2),
    .arb_busy     (arb_busy)
  );

  initial begin
    ext_clk = 1'b0;
    forever #5 ext_clk = ~ext_clk;
  end

  int checks = 0;
  int failures = 0;

  // All observable DUT outputs in one vector.
  logic [31:0] obs;
  assign obs = {sel_usb3, sel_usb2, arb_busy,
                app_if.buf_in_ready, app_if.buf_in_commit_ack, app_if.buf_out_arm_ack,
                app_if.buf_out_hasdata, app_if.buf_out_q, app_if.buf_out_len,
                u3_if.buf_in_wren, u3_if.buf_in_commit, u3_if.buf_out_arm,
                u2_if.buf_in_wren, u2_if.buf_in_commit, u2_if.buf_out_arm};

  // Behavioural model: who holds the bus, who is being considered, and what is outstanding.
  int m_owner;        // 0 nobody, 2 usb2, 3 usb3
  bit m_draining;
  int m_drain_age;
  int m_cand;         // 0 none, 2 or 3 while a link is proving itself
  int m_settle_left;
  bit m_commit_out, m_arm_out;

  function automatic bit link_of(int which);
    return (which == 3) ? u3_link_up : u2_connected;
  endfunction

  task automatic model_step();
    bit ack_c, ack_a, req_c, req_a, lost;
    if (reset) begin
      m_owner = 0; m_draining = 0; m_drain_age = 0;
      m_cand = 0; m_settle_left = 0; m_commit_out = 0; m_arm_out = 0;
      return;
    end
    ack_c = (m_owner == 3) ? u3_if.buf_in_commit_ack : (m_owner == 2) ? u2_if.buf_in_commit_ack : 1'b0;
    ack_a = (m_owner == 3) ? u3_if.buf_out_arm_ack   : (m_owner == 2) ? u2_if.buf_out_arm_ack   : 1'b0;
    if (m_owner != 0 && !m_draining) begin
      req_c = app_if.buf_in_commit;
      req_a = app_if.buf_out_arm;
      m_commit_out = req_c || (m_commit_out && !ack_c);
      m_arm_out    = req_a || (m_arm_out && !ack_a);
      lost = (m_owner == 3) ? !u3_link_up : (!u2_connected || (PREFER && u3_link_up));
      if (lost) begin
        m_draining = 1; m_drain_age = 0;
      end
    end else if (m_draining) begin
      if ((!m_commit_out && !m_arm_out) || m_drain_age == DT - 1) begin
        m_owner = 0; m_draining = 0; m_commit_out = 0; m_arm_out = 0;
      end else begin
        m_commit_out = m_commit_out && !ack_c;
        m_arm_out    = m_arm_out && !ack_a;
        m_drain_age++;
      end
    end else if (m_cand != 0) begin
      if (!link_of(m_cand)) m_cand = 0;
      else if (m_cand == 2 && u3_link_up) begin
        m_cand = 3; m_settle_left = S - 1;
      end else if (m_settle_left == 0) begin
        m_owner = m_cand; m_cand = 0;
      end else m_settle_left--;
    end else begin
      if (u3_link_up) begin
        m_cand = 3; m_settle_left = S - 1;
      end else if (u2_connected) begin
        m_cand = 2; m_settle_left = S - 1;
      end
    end
  endtask

  function automatic logic [31:0] model_expect();
    bit g3, g2;
    logic [31:0] e;
    g3 = (m_owner == 3) && !m_draining;
    g2 = (m_owner == 2) && !m_draining;
    e = '0;
    e[31] = (m_owner == 3);
    e[30] = (m_owner == 2);
    e[29] = (m_cand != 0) || m_draining;
    e[28] = g3 ? u3_if.buf_in_ready : g2 ? u2_if.buf_in_ready : 1'b0;
    if (m_owner == 3)
      e[27:6] = {u3_if.buf_in_commit_ack, u3_if.buf_out_arm_ack, u3_if.buf_out_hasdata,
                 u3_if.buf_out_q, u3_if.buf_out_len};
    else if (m_owner == 2)
      e[27:6] = {u2_if.buf_in_commit_ack, u2_if.buf_out_arm_ack, u2_if.buf_out_hasdata,
                 u2_if.buf_out_q, u2_if.buf_out_len};
    if (g3) e[5:3] = {app_if.buf_in_wren, app_if.buf_in_commit, app_if.buf_out_arm};
    if (g2) e[2:0] = {app_if.buf_in_wren, app_if.buf_in_commit, app_if.buf_out_arm};
    return e;
  endfunction

  task automatic tick();
    @(posedge ext_clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    u3_link_up = 0; u2_connected = 0;
    app_if.buf_in_wren = 0; app_if.buf_in_commit = 0; app_if.buf_out_arm = 0;
    u3_if.buf_in_ready = 0; u3_if.buf_in_commit_ack = 0; u3_if.buf_out_arm_ack = 0;
    u3_if.buf_out_hasdata = 0; u3_if.buf_out_q = 0; u3_if.buf_out_len = 0;
    u2_if.buf_in_ready = 0; u2_if.buf_in_commit_ack = 0; u2_if.buf_out_arm_ack = 0;
    u2_if.buf_out_hasdata = 0; u2_if.buf_out_q = 0; u2_if.buf_out_len = 0;
  endtask

  task automatic randomize_core_returns();
    u3_if.buf_in_ready = 1'($urandom); u3_if.buf_out_hasdata = 1'($urandom);
    u3_if.buf_out_q = 8'($urandom); u3_if.buf_out_len = 11'($urandom);
    u2_if.buf_in_ready = 1'($urandom); u2_if.buf_out_hasdata = 1'($urandom);
    u2_if.buf_out_q = 8'($urandom); u2_if.buf_out_len = 11'($urandom);
    u3_if.buf_in_commit_ack = ($urandom_range(0, 3) == 0);
    u3_if.buf_out_arm_ack   = ($urandom_range(0, 3) == 0);
    u2_if.buf_in_commit_ack = ($urandom_range(0, 3) == 0);
    u2_if.buf_out_arm_ack   = ($urandom_range(0, 3) == 0);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    randomize_core_returns();
    app_if.buf_in_wren = 1; app_if.buf_in_commit = 1; app_if.buf_out_arm = 1;
    #1;
    checks++;
    if (obs !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 32'h0);
    end
    clear_inputs();
    reset = 0;
    tick();
    checks++;
    if (arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", arb_busy);
    end
  endtask

  task automatic test_u2_settle();
    int n = 0;
    bit leak = 0;
    u2_connected = 1;
    app_if.buf_in_wren = 1; app_if.buf_in_commit = 1; app_if.buf_out_arm = 1;
    u2_if.buf_in_ready = 1;
    do begin
      tick();
      n++;
      if (sel_usb3 || u3_if.buf_in_wren || u3_if.buf_in_commit || u3_if.buf_out_arm) leak = 1;
      if (!sel_usb2 && app_if.buf_in_ready) leak = 1;
    end while (!sel_usb2 && n < 4 * S);
    app_if.buf_in_wren = 0; app_if.buf_in_commit = 0; app_if.buf_out_arm = 0;
    #1;
    checks++;
    if (n !== S + 1) begin
      failures++;
      $display("FAIL u2_grant_latency got=%0d exp=%0d", n, S + 1);
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL u2_settle_isolation got=1 exp=0");
    end
    checks++;
    if ({arb_busy, app_if.buf_in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL u2_owned_status got=%b exp=01", {arb_busy, app_if.buf_in_ready});
    end
    app_if.buf_in_wren = 1;
    #1;
    checks++;
    if ({u2_if.buf_in_wren, u3_if.buf_in_wren} !== 2'b10) begin
      failures++;
      $display("FAIL u2_wren_forward got=%b exp=10", {u2_if.buf_in_wren, u3_if.buf_in_wren});
    end
    app_if.buf_in_wren = 0;
  endtask

  task automatic test_u2_pulse();
    // Leave the current owner, then give usb2 a short blip.
    clear_inputs();
    tick(); tick(); tick();
    u2_connected = 1;
    repeat (5) tick();
    checks++;
    if (arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL pulse_settling got=%b exp=1", arb_busy);
    end
    u2_connected = 0;
    tick();
    checks++;
    if ({sel_usb3, sel_usb2, arb_busy} !== 3'b000) begin
      failures++;
      $display("FAIL pulse_abandon got=%b exp=000", {sel_usb3, sel_usb2, arb_busy});
    end
  endtask

  task automatic test_preempt();
    int n = 0;
    bit both = 0;
    u2_connected = 1;
    repeat (S + 1) tick();
    checks++;
    if (sel_usb2 !== 1'b1) begin
      failures++;
      $display("FAIL preempt_setup got=%b exp=1", sel_usb2);
    end
    u3_link_up = 1;
    do begin
      tick();
      n++;
      if (sel_usb3 && sel_usb2) both = 1;
    end while (!sel_usb3 && n < 4 * S);
    checks++;
    if (n !== S + 3) begin
      failures++;
      $display("FAIL preempt_latency got=%0d exp=%0d", n, S + 3);
    end
    checks++;
    if (both || sel_usb2 !== 1'b0) begin
      failures++;
      $display("FAIL preempt_exclusive got=%b exp=0", both | sel_usb2);
    end
  endtask

  task automatic test_drain_ack();
    bit held = 1;
    app_if.buf_in_commit = 1;
    u3_link_up = 0;
    u3_if.buf_in_ready = 1;
    #1;
    checks++;
    if (u3_if.buf_in_commit !== 1'b1) begin
      failures++;
      $display("FAIL drop_commit_forward got=%b exp=1", u3_if.buf_in_commit);
    end
    tick();
    app_if.buf_in_commit = 0;
    repeat (5) begin
      tick();
      if (!arb_busy || !sel_usb3 || app_if.buf_in_ready) held = 0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL drain_holds got=0 exp=1");
    end
    u3_if.buf_in_commit_ack = 1;
    #1;
    checks++;
    if (app_if.buf_in_commit_ack !== 1'b1) begin
      failures++;
      $display("FAIL drain_ack_route got=%b exp=1", app_if.buf_in_commit_ack);
    end
    tick();
    u3_if.buf_in_commit_ack = 0;
    tick();
    checks++;
    if ({sel_usb3, arb_busy} !== 2'b00) begin
      failures++;
      $display("FAIL drain_release got=%b exp=00", {sel_usb3, arb_busy});
    end
  endtask

  task automatic test_drain_timeout();
    int n = 0;
    bit ready_seen = 0;
    clear_inputs();
    u2_connected = 1;
    repeat (S + 1) tick();
    u2_if.buf_in_ready = 1;
    app_if.buf_out_arm = 1;
    u2_connected = 0;
    tick();
    app_if.buf_out_arm = 0;
    do begin
      if (app_if.buf_in_ready) ready_seen = 1;
      tick();
      n++;
    end while (arb_busy && n < 4 * DT);
    checks++;
    if (n !== DT) begin
      failures++;
      $display("FAIL drain_timeout_len got=%0d exp=%0d", n, DT);
    end
    checks++;
    if (ready_seen || sel_usb2) begin
      failures++;
      $display("FAIL drain_timeout_ready got=%b exp=0", ready_seen | sel_usb2);
    end
  endtask

  task automatic test_reset_mid_drain();
    clear_inputs();
    u3_link_up = 1;
    repeat (S + 1) tick();
    app_if.buf_in_commit = 1;
    u3_link_up = 0;
    tick();
    app_if.buf_in_commit = 0;
    tick(); tick();
    checks++;
    if ({sel_usb3, arb_busy} !== 2'b11) begin
      failures++;
      $display("FAIL mid_drain_setup got=%b exp=11", {sel_usb3, arb_busy});
    end
    reset = 1;
    tick();
    randomize_core_returns();
    #1;
    checks++;
    if (obs !== 32'h0) begin
      failures++;
      $display("FAIL mid_drain_reset got=%h exp=%h", obs, 32'h0);
    end
    reset = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 44) == 0) u3_link_up = ~u3_link_up;
      if ($urandom_range(0, 29) == 0) u2_connected = ~u2_connected;
      app_if.buf_in_wren   = ($urandom_range(0, 2) == 0);
      app_if.buf_in_commit = ($urandom_range(0, 5) == 0);
      app_if.buf_out_arm   = ($urandom_range(0, 5) == 0);
      randomize_core_returns();
      #1;
      checks++;
      if (obs !== model_expect()) begin
        failures++;
        $display("FAIL random_cycle_%0d got=%h exp=%h", c, obs, model_expect());
      end
      if (sel_usb3 && sel_usb2) begin
        failures++;
        $display("FAIL random_both_sel cycle=%0d", c);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_u2_settle();
    test_u2_pulse();
    test_preempt();
    test_drain_ack();
    test_drain_timeout();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
